// File: rtl/lzw_pkg.sv
// Shared LZW definitions: default code width and the packer FSM encoding.
package lzw_pkg;

    localparam int LZW_CODE_W = 12;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        PAD
    } packer_state_t;

endpackage

// File: rtl/lzw_code_packer_if.sv
// Code-in / byte-out handshake bundle between the compressor, the packer and the sink.
interface lzw_code_packer_if
    import lzw_pkg::*;
#(
    parameter int CODE_W = LZW_CODE_W
);
    logic [CODE_W-1:0] code_i;
    logic              code_valid_i;
    logic              code_last_i;
    logic              code_ready_o;
    logic [7:0]        byte_o;
    logic              byte_valid_o;
    logic              byte_ready_i;
    logic              byte_last_o;
    logic [15:0]       block_bytes_o;

    modport master (
        output code_i, code_valid_i, code_last_i, byte_ready_i,
        input  code_ready_o, byte_o, byte_valid_o, byte_last_o, block_bytes_o
    );

    modport slave (
        input  code_i, code_valid_i, code_last_i, byte_ready_i,
        output code_ready_o, byte_o, byte_valid_o, byte_last_o, block_bytes_o
    );
endinterface

// File: rtl/lzw_code_packer.sv
// Packs fixed-width LZW codes MSB-first into bytes; last byte of a block zero-padded.
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int CODE_W = LZW_CODE_W
) (
    input  logic clk,
    input  logic reset_i,
    lzw_code_packer_if.slave bus
);
    localparam int ACC_W = CODE_W + 7;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] CNT_CODE = CNT_W'(CODE_W);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    packer_state_t    state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [15:0]      run_q, run_d;
    logic [15:0]      blk_q, blk_d;

    logic [CNT_W-1:0] cnt_sub;
    logic [15:0]      run_inc;
    logic             eob;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ACCEPT;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            run_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            run_q   <= run_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        run_d   = run_q;
        blk_d   = blk_q;
        eob     = 1'b0;
        cnt_sub = cnt_q - CNT_BYTE;
        run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

        case (state_q)
            ACCEPT: begin
                if (cnt_q >= CNT_BYTE) begin
                    cnt_d = CNT_ZERO;
                    acc_d = '0;
                end else if (bus.code_valid_i) begin
                    // New code lands directly below the bits still waiting
                    acc_d   = acc_q | ({bus.code_i, 7'b0} >> cnt_q);
                    cnt_d   = cnt_q + CNT_CODE;
                    last_d  = last_q | bus.code_last_i;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q < CNT_BYTE) begin
                    state_d = ACCEPT;
                    cnt_d   = CNT_ZERO;
                    acc_d   = '0;
                end else if (bus.byte_ready_i) begin
                    acc_d = acc_q << 8;
                    cnt_d = cnt_sub;
                    run_d = run_inc;
                    if (cnt_sub >= CNT_BYTE) state_d = DRAIN;
                    else if (last_q && cnt_sub != CNT_ZERO) state_d = PAD;
                    else if (last_q) eob = 1'b1;
                    else state_d = ACCEPT;
                end
            end
            PAD: begin
                if (cnt_q == CNT_ZERO || cnt_q >= CNT_BYTE) begin
                    state_d = ACCEPT;
                    cnt_d   = CNT_ZERO;
                    acc_d   = '0;
                end else if (bus.byte_ready_i) begin
                    eob = 1'b1;
                end
            end
            default: begin
                state_d = ACCEPT;
                cnt_d   = CNT_ZERO;
                acc_d   = '0;
            end
        endcase

        if (eob) begin
            blk_d   = run_inc;
            run_d   = '0;
            cnt_d   = CNT_ZERO;
            acc_d   = '0;
            last_d  = 1'b0;
            state_d = ACCEPT;
        end
    end

    logic drain_st, pad_st;
    assign drain_st = (state_q == DRAIN);
    assign pad_st   = (state_q == PAD);

    assign bus.code_ready_o  = (state_q == ACCEPT) && (cnt_q < CNT_BYTE);
    assign bus.byte_valid_o  = drain_st || pad_st;
    // Bits below the valid ones are always zero, so PAD needs no masking
    assign bus.byte_o        = bus.byte_valid_o ? acc_q[ACC_W-1 -: 8] : 8'h00;
    assign bus.byte_last_o   = pad_st || (drain_st && last_q && cnt_q == CNT_BYTE);
    assign bus.block_bytes_o = blk_q;

endmodule

// File: tb/tb_lzw_code_packer.sv
// Directed table-driven bench for lzw_code_packer at CODE_W = 12.
module tb_lzw_code_packer;
    import lzw_pkg::*;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    lzw_code_packer_if #(.CODE_W(12)) bus ();

    lzw_code_packer #(.CODE_W(12)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    typedef struct {
        int          ncodes;
        logic [11:0] codes [4];
        int          nbytes;
        logic [7:0]  bytes [6];
        logic [15:0] blk;
    } block_t;

    block_t tbl [4];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code_ready"}, 32'(bus.code_ready_o), 32'd1);
        check({tag, "_byte_valid"}, 32'(bus.byte_valid_o), 32'd0);
        check({tag, "_byte"}, 32'(bus.byte_o), 32'h00);
        check({tag, "_byte_last"}, 32'(bus.byte_last_o), 32'd0);
        check({tag, "_block_bytes"}, 32'(bus.block_bytes_o), 32'd0);
    endtask

    task automatic run_block(input int bi, input int stall_idx, output int cycles);
        int ci = 0;
        int bx = 0;
        int cyc = 0;
        int stall = 0;
        while (bx < tbl[bi].nbytes && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.code_valid_i = 1'b0;
            bus.code_last_i  = 1'b1;
            bus.byte_ready_i = 1'b0;
            bus.code_i       = 12'hFFF;
            check("excl", 32'(bus.code_ready_o & bus.byte_valid_o), 32'd0);
            if (ci < tbl[bi].ncodes) begin
                bus.code_i       = tbl[bi].codes[ci];
                bus.code_valid_i = 1'b1;
                bus.code_last_i  = (ci == tbl[bi].ncodes - 1);
                if (bus.code_ready_o) ci++;
            end
            if (bus.byte_valid_o) begin
                check($sformatf("b%0d_byte%0d", bi, bx), 32'(bus.byte_o), 32'(tbl[bi].bytes[bx]));
                check($sformatf("b%0d_last%0d", bi, bx), 32'(bus.byte_last_o),
                      32'(bx == tbl[bi].nbytes - 1));
                if (bx == stall_idx && stall < 5) begin
                    check("stall_code_ready", 32'(bus.code_ready_o), 32'd0);
                    stall++;
                end else begin
                    bus.byte_ready_i = 1'b1;
                    bx++;
                end
            end
        end
        cycles = cyc;
        check($sformatf("b%0d_done", bi), 32'(bx), 32'(tbl[bi].nbytes));
        check($sformatf("b%0d_codes", bi), 32'(ci), 32'(tbl[bi].ncodes));
        @(negedge clk);
        bus.code_valid_i = 1'b0;
        bus.byte_ready_i = 1'b0;
        check($sformatf("b%0d_block_bytes", bi), 32'(bus.block_bytes_o), 32'(tbl[bi].blk));
        check($sformatf("b%0d_idle", bi), 32'(bus.code_ready_o), 32'd1);
    endtask

    initial begin
        int cyc;
        tbl[0].ncodes = 2; tbl[0].codes[0] = 12'h123; tbl[0].codes[1] = 12'h456;
        tbl[0].nbytes = 3; tbl[0].bytes[0] = 8'h12; tbl[0].bytes[1] = 8'h34;
        tbl[0].bytes[2] = 8'h56; tbl[0].blk = 16'd3;
        tbl[1].ncodes = 1; tbl[1].codes[0] = 12'hABC;
        tbl[1].nbytes = 2; tbl[1].bytes[0] = 8'hAB; tbl[1].bytes[1] = 8'hC0;
        tbl[1].blk = 16'd2;
        tbl[2].ncodes = 3; tbl[2].codes[0] = 12'h001; tbl[2].codes[1] = 12'h002;
        tbl[2].codes[2] = 12'h003;
        tbl[2].nbytes = 5; tbl[2].bytes[0] = 8'h00; tbl[2].bytes[1] = 8'h10;
        tbl[2].bytes[2] = 8'h02; tbl[2].bytes[3] = 8'h00; tbl[2].bytes[4] = 8'h30;
        tbl[2].blk = 16'd5;
        tbl[3].ncodes = 1; tbl[3].codes[0] = 12'h0FF;
        tbl[3].nbytes = 2; tbl[3].bytes[0] = 8'h0F; tbl[3].bytes[1] = 8'hF0;
        tbl[3].blk = 16'd2;

        bus.code_i = '0;
        bus.code_valid_i = 1'b0;
        bus.code_last_i = 1'b0;
        bus.byte_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        run_block(0, -1, cyc);
        check("throughput_cycles", 32'(cyc), 32'd5);
        run_block(1, -1, cyc);
        run_block(2, -1, cyc);
        run_block(0, 1, cyc);

        // Reset after the first byte of a block leaves 4 bits pending
        @(negedge clk);
        bus.code_i = 12'h123;
        bus.code_valid_i = 1'b1;
        bus.code_last_i = 1'b0;
        @(negedge clk);
        bus.code_valid_i = 1'b0;
        check("mid_byte", 32'(bus.byte_o), 32'h12);
        bus.byte_ready_i = 1'b1;
        @(negedge clk);
        bus.byte_ready_i = 1'b0;
        check("mid_accept", 32'(bus.code_ready_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        reset_i = 1'b0;
        check_reset_outputs("mid_rst_rel");
        run_block(3, -1, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lzw_code_packer.md
# lzw_code_packer

Downstream stage of the LZW compressor: consumes the compressor's fixed-width code stream over a valid/ready handshake and packs it MSB-first into a byte stream for the output interface. Codes of CODE_W bits are concatenated with no gaps. The final byte of a block is zero-padded and flagged with byte_last_o. Every block is framed by the compressor's code_last_i.

## Interface
- CODE_W, default 12, code width in bits; legal range 9..16.
- clk  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- code_i  in  CODE_W  LZW code from the compressor.
- code_valid_i  in  1  code_i valid.
- code_last_i  in  1  code_i is the final code of the block; qualified by code_valid_i.
- code_ready_o  out  1  packer accepts a code this cycle.
- byte_o  out  8  packed output byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  downstream accepts byte_o.
- byte_last_o  out  1  byte_o is the final byte of the block.
- block_bytes_o  out  16  byte count of the most recently completed block; holds until the next block completes.

## Operation
- Internal state:
  - Accumulator acc, CODE_W+7 bits, left-aligned; valid bits occupy the top bits.
  - Bit counter cnt, 0..CODE_W+7.
  - Sticky flag last_seen.
  - Running byte counter run_cnt, 16 bits, saturating at 0xFFFF.
- States:
  - ACCEPT
    - Holds cnt <= 7; code_ready_o = 1.
    - On code handshake: append code_i below the valid bits; cnt += CODE_W; last_seen |= code_last_i; go to DRAIN.
  - DRAIN
    - Holds cnt >= 8; byte_valid_o = 1; byte_o = top 8 bits of acc.
    - byte_last_o = last_seen && cnt == 8.
    - On byte handshake: shift acc left 8; cnt -= 8; run_cnt += 1. Next state:
      - new cnt >= 8: stay in DRAIN.
      - last_seen and new cnt in 1..7: go to PAD.
      - last_seen and new cnt == 0: end of block (see below).
      - otherwise: go to ACCEPT.
  - PAD
    - byte_valid_o = 1; byte_last_o = 1; byte_o = remaining cnt bits left-aligned, low bits 0.
    - On byte handshake: end of block.
- End of block:
  - block_bytes_o <= run_cnt + 1 (the final byte included).
  - run_cnt, cnt, acc and last_seen cleared.
  - Go to ACCEPT.
- code_ready_o and byte_valid_o are never both 1.
- code_last_i is ignored when code_valid_i is low.
- Arithmetic:
  - cnt updates are unsigned.
  - The invariants above guarantee cnt never exceeds CODE_W+7.
  - A state/cnt combination outside the invariants (illegal) returns to ACCEPT with cnt cleared.

## Timing
- Reset values:
  - state ACCEPT; acc = 0; cnt = 0; last_seen = 0; run_cnt = 0.
  - code_ready_o = 1; byte_valid_o = 0; byte_o = 0x00; byte_last_o = 0; block_bytes_o = 0.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Latency: code accepted at edge N → first byte valid during cycle N+1.
- Throughput at CODE_W=12 with no backpressure: 2 codes in 5 cycles (2 accept + 3 byte).
- Backpressure: while byte_valid_o = 1 and byte_ready_i = 0, byte_o and byte_last_o hold stable.
- A code offered while code_ready_o = 0 is not consumed; the upstream must hold it until code_ready_o = 1.
- Reset mid-block: the partial block is discarded, no byte is emitted, and all outputs immediately take their reset values.
- block_bytes_o updates on the edge of the final byte handshake and is visible the next cycle.

## Structure
- Shared package lzw_pkg holds:
  - localparam LZW_CODE_W = 12 (default for CODE_W here and for the compressor's code width).
  - typedef enum logic [1:0] packer_state_t {ACCEPT, DRAIN, PAD}.
- Single module; no sub-module is warranted. The accumulator and counter stay inline.

## Test plan
- Codes 0x123, 0x456 (last on 0x456), byte_ready_i = 1 → bytes 0x12, 0x34, 0x56; byte_last_o on 0x56; block_bytes_o = 3.
- Single code 0xABC with last → bytes 0xAB, 0xC0 (last); block_bytes_o = 2.
- Codes 0x001, 0x002, 0x003 (last on 0x003) → bytes 0x00, 0x10, 0x02, 0x00, 0x30 (last); block_bytes_o = 5.
- Repeat the first scenario with byte_ready_i low for 5 cycles while 0x34 is presented → 0x34 held stable; code_ready_o = 0 throughout; output sequence unchanged.
- Assert reset_i for one cycle after byte 0x12 of the first scenario → outputs at reset values; a fresh code 0x0FF with last → bytes 0x0F, 0xF0 (last).
- Two back-to-back blocks (0x123/0x456, then 0xABC) → block_bytes_o reads 3 then 2; no bits leak between blocks.
